font_loader: RTL and testbench

Byte-stream glyph loader that writes character bitmaps into the font RAM read by the `font` pixel streamer. It accepts framed glyph records over a valid/ready byte interface (typically fed by the UART receiver) and verifies each frame's checksum. Only verified glyphs are committed, as eight row writes on the font RAM write port, so a corrupted frame never alters the displayed font.

---
 rtl/font_loader.sv | 172 +++++++++++++++++
 tb/tb_font_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/font_loader.sv
// Framed glyph loader: receives SYNC, CHAR, ROW0..ROW7, CSUM over a valid/ready byte
// stream and commits checksum-verified glyphs to the font RAM as eight row writes.
module font_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        px_clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] glyph_count
);

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_CHAR   = 3'd1,
        ST_ROWS   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  k_r;
    logic [2:0]  k_s;
    logic [2:0]  row_r;
    logic [7:0]  char_r;
    logic [7:0]  csum_r;
    logic [7:0]  rows_r [0:7];
    logic        accept_s;
    logic        csum_match_s;
    logic        commit_last_s;

    logic        in_ready_r;
    logic        wr_en_r;
    logic [10:0] wr_addr_r;
    logic [7:0]  wr_data_r;
    logic        frame_ok_r;
    logic        frame_err_r;
    logic [15:0] glyph_count_r;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign in_ready    = in_ready_r;
    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign frame_ok    = frame_ok_r;
    assign frame_err   = frame_err_r;
    assign glyph_count = glyph_count_r;

    // Next-state and commit-row counter decode
    always_comb begin
        state_s       = state_r;
        k_s           = k_r;
        accept_s      = in_valid && in_ready_r;
        csum_match_s  = (in_data == csum_r);
        case (state_r)
            ST_SYNC: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_s = ST_CHAR;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_CHAR: begin
                if (accept_s) begin
                    state_s = ST_ROWS;
                end else begin
                    state_s = ST_CHAR;
                end
            end
            ST_ROWS: begin
                if (accept_s && (row_r == 3'd7)) begin
                    state_s = ST_CSUM;
                end else begin
                    state_s = ST_ROWS;
                end
            end
            ST_CSUM: begin
                if (accept_s && csum_match_s) begin
                    state_s = ST_COMMIT;
                    k_s     = 3'd0;
                end else if (accept_s) begin
                    state_s = ST_SYNC;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_COMMIT: begin
                if (k_r == 3'd7) begin
                    state_s = ST_SYNC;
                    k_s     = 3'd0;
                end else begin
                    k_s     = k_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_SYNC;
                k_s     = 3'd0;
            end
        endcase
        commit_last_s = (state_s == ST_COMMIT) && (k_s == 3'd7);
    end

    // State, frame capture and running checksum
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_SYNC;
            k_r     <= 3'd0;
            row_r   <= 3'd0;
            char_r  <= 8'd0;
            csum_r  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                rows_r[i] <= 8'd0;
            end
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            if (accept_s) begin
                case (state_r)
                    ST_CHAR: begin
                        char_r <= in_data;
                        csum_r <= in_data;
                        row_r  <= 3'd0;
                    end
                    ST_ROWS: begin
                        rows_r[row_r] <= in_data;
                        csum_r        <= csum_step(csum_r, in_data);
                        row_r         <= row_r + 3'd1;
                    end
                    default: begin
                        row_r <= row_r;
                    end
                endcase
            end
        end
    end

    // Registered outputs, computed from the next state so they align with it
    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            in_ready_r    <= 1'b1;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= 11'd0;
            wr_data_r     <= 8'd0;
            frame_ok_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            glyph_count_r <= 16'd0;
        end else begin
            in_ready_r  <= (state_s != ST_COMMIT);
            wr_en_r     <= (state_s == ST_COMMIT);
            frame_ok_r  <= commit_last_s;
            frame_err_r <= (state_r == ST_CSUM) && accept_s && !csum_match_s;
            if (state_s == ST_COMMIT) begin
                wr_addr_r <= {char_r, k_s};
                wr_data_r <= rows_r[k_s];
            end
            if (commit_last_s && (glyph_count_r != 16'hFFFF)) begin
                glyph_count_r <= glyph_count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_font_loader.sv
// Self-checking bench for font_loader: table of directed frames, reset corner cases,
// and a randomized throttled stream checked against a frame-parsing reference model.
module tb_font_loader;

    logic        px_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] glyph_count;

    font_loader #(.SYNC_BYTE(8'hA5)) dut (
        .px_clk(px_clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .glyph_count(glyph_count)
    );

    always #5 px_clk = ~px_clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]  sent_q[$];
    logic [19:0] obs_q[$];
    int ok_seen = 0;
    int err_seen = 0;
    int glyph_model = 0;

    typedef struct {
        logic [7:0]  ch;
        logic [63:0] rows;
        logic [7:0]  csum;
        logic        exp_ok;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: collect writes and pulses; in_ready must be low exactly while writing
    always @(negedge px_clk) begin
        check("ready_vs_commit", 32'(in_ready), 32'(!wr_en));
        if (wr_en) obs_q.push_back({frame_ok, wr_addr, wr_data});
        else if (frame_ok) check("frame_ok_without_write", 32'(frame_ok), 32'd0);
        if (frame_ok) ok_seen++;
        if (frame_err) err_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int duty);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 400) begin
            @(negedge px_clk);
            in_valid = ($urandom_range(0, 99) < duty);
            in_data  = in_valid ? b : 8'($urandom);
            acc      = in_valid && in_ready;
            @(posedge px_clk);
            tries++;
        end
        #1;
        in_valid = 1'b0;
        if (acc) sent_q.push_back(b);
        else check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [63:0] rows,
                              input logic [7:0] csum, input int duty);
        send_byte(8'hA5, duty);
        send_byte(ch, duty);
        for (int r = 0; r < 8; r++) send_byte(rows[63-8*r -: 8], duty);
        send_byte(csum, duty);
    endtask

    // Reference model: parse the accepted byte stream into frames and compare
    task automatic check_scenario(input string name);
        logic [19:0] exp_q[$];
        int exp_ok = 0;
        int exp_err = 0;
        int i = 0;
        logic [7:0] x;
        repeat (12) @(negedge px_clk);
        #1;
        while (i < sent_q.size()) begin
            if (sent_q[i] != 8'hA5) begin
                i++;
            end else if (i + 10 >= sent_q.size()) begin
                i = sent_q.size();
            end else begin
                x = 8'd0;
                for (int j = 1; j <= 9; j++) x = x ^ sent_q[i+j];
                if (x == sent_q[i+10]) begin
                    for (int r = 0; r < 8; r++)
                        exp_q.push_back({(r == 7), sent_q[i+1], 3'(r), sent_q[i+2+r]});
                    exp_ok++;
                    if (glyph_model < 65535) glyph_model++;
                end else begin
                    exp_err++;
                end
                i += 11;
            end
        end
        check({name, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check({name, "_write"}, 32'(obs_q[k]), 32'(exp_q[k]));
        check({name, "_frame_ok_count"}, 32'(ok_seen), 32'(exp_ok));
        check({name, "_frame_err_count"}, 32'(err_seen), 32'(exp_err));
        check({name, "_glyph_count"}, 32'(glyph_count), 32'(glyph_model));
        sent_q.delete();
        obs_q.delete();
        ok_seen  = 0;
        err_seen = 0;
    endtask

    task automatic commit_timing(input int g0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge px_clk);
            check("commit_wr_en", 32'(wr_en), 32'(c <= 8));
            check("commit_in_ready", 32'(in_ready), 32'(c > 8));
            check("commit_frame_ok", 32'(frame_ok), 32'(c == 8));
            check("commit_glyph_count", 32'(glyph_count), 32'((c >= 8) ? g0 + 1 : g0));
        end
    endtask

    task automatic err_timing();
        @(negedge px_clk);
        check("err_pulse", 32'(frame_err), 32'd1);
        check("err_in_ready", 32'(in_ready), 32'd1);
        check("err_no_write", 32'(wr_en), 32'd0);
        @(negedge px_clk);
        check("err_pulse_single", 32'(frame_err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_wr_en"}, 32'(wr_en), 32'd0);
        check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({name, "_wr_data"}, 32'(wr_data), 32'd0);
        check({name, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_glyph_count"}, 32'(glyph_count), 32'd0);
    endtask

    initial begin
        logic [63:0] rows;
        logic [7:0]  ch;
        logic [7:0]  cs;
        logic [7:0]  g;
        int          w;
        int          t;

        vecs[0] = '{ch: 8'h41, rows: 64'h183C66667E666600, csum: 8'h1B, exp_ok: 1'b1};
        vecs[1] = '{ch: 8'h41, rows: 64'h183C66667E666600, csum: 8'h1A, exp_ok: 1'b0};
        vecs[2] = '{ch: 8'h42, rows: 64'h7C66667C66667C00, csum: 8'h3E, exp_ok: 1'b1};
        vecs[3] = '{ch: 8'h43, rows: 64'h0000A50000000000, csum: 8'hE6, exp_ok: 1'b1};

        #12;
        check_reset_outputs("reset");
        @(negedge px_clk);
        resetn = 1'b1;

        send_byte(8'h00, 100);
        send_byte(8'hFF, 100);
        send_byte(8'h13, 100);
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].ch, vecs[v].rows, vecs[v].csum, 100);
            if (vecs[v].exp_ok) commit_timing(glyph_model);
            else err_timing();
            check("vec_frame_ok", 32'(ok_seen), 32'(vecs[v].exp_ok));
            check("vec_frame_err", 32'(err_seen), 32'(!vecs[v].exp_ok));
            if (vecs[v].exp_ok) begin
                check("vec_last_addr", 32'(obs_q[7][18:8]), 32'({vecs[v].ch, 3'd7}));
                check("vec_row2_data", 32'(obs_q[2][7:0]), 32'(vecs[v].rows[47:40]));
            end
            check_scenario("vector");
        end

        send_frame(8'h41, 64'h183C66667E666600, 8'h1B, 30);
        check_scenario("throttled");

        send_byte(8'hA5, 100);
        send_byte(8'h41, 100);
        send_byte(8'h18, 100);
        send_byte(8'h3C, 100);
        send_byte(8'h66, 100);
        send_byte(8'h66, 100);
        send_byte(8'h7E, 100);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        check("midframe_no_writes", 32'(obs_q.size()), 32'd0);
        @(negedge px_clk);
        resetn = 1'b1;
        sent_q.delete();
        obs_q.delete();
        ok_seen = 0;
        err_seen = 0;
        glyph_model = 0;
        send_frame(8'h41, 64'h183C66667E666600, 8'h1B, 100);
        check_scenario("after_midframe_reset");

        send_frame(8'h41, 64'h183C66667E666600, 8'h1B, 100);
        w = 0;
        t = 0;
        while (w < 3 && t < 50) begin
            @(negedge px_clk);
            if (wr_en) w++;
            t++;
        end
        check("midcommit_three_writes", 32'(w), 32'd3);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midcommit_reset");
        check("midcommit_partial_writes", 32'(obs_q.size()), 32'd3);
        check("midcommit_no_frame_ok", 32'(ok_seen), 32'd0);
        @(negedge px_clk);
        resetn = 1'b1;
        sent_q.delete();
        obs_q.delete();
        ok_seen = 0;
        err_seen = 0;
        glyph_model = 0;

        for (int f = 0; f < 30; f++) begin
            for (int n = 0; n < $urandom_range(0, 2); n++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 100);
            end
            ch = 8'($urandom);
            rows = {32'($urandom), 32'($urandom)};
            cs = ch;
            for (int r = 0; r < 8; r++) cs = cs ^ rows[63-8*r -: 8];
            if ($urandom_range(0, 99) < 30) cs = cs ^ 8'($urandom_range(1, 255));
            send_frame(ch, rows, cs, $urandom_range(30, 100));
        end
        check_scenario("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
